// File: rtl/keyvalue_arbiter.sv
// keyvalue_arbiter: round-robin two-port arbiter sharing one key-value store, with ACK timeout abort.
module keyvalue_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          A_STB_i,
  input  logic          A_WE_i,
  input  logic [AW-1:0] A_ADR_i,
  input  logic [DW-1:0] A_DAT_i,
  output logic [DW-1:0] A_DAT_o,
  output logic          A_ACK_o,
  output logic          A_ERR_o,
  input  logic          B_STB_i,
  input  logic          B_WE_i,
  input  logic [AW-1:0] B_ADR_i,
  input  logic [DW-1:0] B_DAT_i,
  output logic [DW-1:0] B_DAT_o,
  output logic          B_ACK_o,
  output logic          B_ERR_o,
  output logic          M_STB_o,
  output logic          M_WE_o,
  output logic [AW-1:0] M_ADR_o,
  output logic [DW-1:0] M_DAT_o,
  input  logic [DW-1:0] M_DAT_i,
  input  logic          M_ACK_i,
  output logic [1:0]    grant_o,
  output logic          busy_o,
  output logic [7:0]    err_cnt_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m_stb_q, m_stb_d, m_we_q, m_we_d;
  logic [AW-1:0] m_adr_q, m_adr_d;
  logic [DW-1:0] m_dat_q, m_dat_d, a_dat_q, a_dat_d, b_dat_q, b_dat_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d, a_err_q, a_err_d, b_err_q, b_err_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          pick_b, own_b;
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_stb_d   = m_stb_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    a_dat_d   = a_dat_q;
    b_dat_d   = b_dat_q;
    grant_d   = grant_q;
    err_cnt_d = err_cnt_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_err_d   = 1'b0;
    b_err_d   = 1'b0;
    // last_q = 1 means B owned the previous grant, so a tie goes to A
    pick_b    = B_STB_i & (~A_STB_i | ~last_q);
    own_b     = grant_q[1];
    if (state_q == IDLE) begin
      if (A_STB_i | B_STB_i) begin
        m_we_d  = pick_b ? B_WE_i : A_WE_i;
        m_adr_d = pick_b ? B_ADR_i : A_ADR_i;
        m_dat_d = pick_b ? B_DAT_i : A_DAT_i;
        m_stb_d = 1'b1;
        grant_d = pick_b ? 2'b10 : 2'b01;
        last_d  = pick_b;
        cnt_d   = '0;
        state_d = BUSY;
      end
    end else if (state_q == BUSY) begin
      if (M_ACK_i) begin
        m_stb_d = 1'b0;
        a_ack_d = ~own_b;
        b_ack_d = own_b;
        a_dat_d = (~m_we_q & ~own_b) ? M_DAT_i : a_dat_q;
        b_dat_d = (~m_we_q & own_b) ? M_DAT_i : b_dat_q;
        state_d = DONE;
      end else if (cnt_q == TMAX) begin
        m_stb_d   = 1'b0;
        a_err_d   = ~own_b;
        b_err_d   = own_b;
        err_cnt_d = err_cnt_q + 8'(err_cnt_q != 8'hFF);
        state_d   = DONE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      grant_d = 2'b00;
      state_d = IDLE;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      m_stb_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
      m_dat_q   <= '0;
      a_dat_q   <= '0;
      b_dat_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      grant_q   <= 2'b00;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_stb_q   <= m_stb_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_dat_q   <= m_dat_d;
      a_dat_q   <= a_dat_d;
      b_dat_q   <= b_dat_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      grant_q   <= grant_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign A_DAT_o   = a_dat_q;
  assign B_DAT_o   = b_dat_q;
  assign A_ACK_o   = a_ack_q;
  assign B_ACK_o   = b_ack_q;
  assign A_ERR_o   = a_err_q;
  assign B_ERR_o   = b_err_q;
  assign M_STB_o   = m_stb_q;
  assign M_WE_o    = m_we_q;
  assign M_ADR_o   = m_adr_q;
  assign M_DAT_o   = m_dat_q;
  assign grant_o   = grant_q;
  assign busy_o    = state_q != IDLE;
  assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_keyvalue_arbiter.sv
// tb_keyvalue_arbiter: scoreboard bench for keyvalue_arbiter with a behavioural store responder.
module tb_keyvalue_arbiter;
  logic       sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic       A_STB_i = 0, A_WE_i = 0, B_STB_i = 0, B_WE_i = 0;
  logic [7:0] A_ADR_i = 0, A_DAT_i = 0, B_ADR_i = 0, B_DAT_i = 0;
  logic [7:0] A_DAT_o, B_DAT_o, M_ADR_o, M_DAT_o, err_cnt_o;
  logic       A_ACK_o, A_ERR_o, B_ACK_o, B_ERR_o, M_STB_o, M_WE_o, busy_o;
  logic [7:0] M_DAT_i = 0;
  logic       M_ACK_i = 0;
  logic [1:0] grant_o;
  int checks = 0, errors = 0;
  int ack_lat = 0, stb_len = 0;
  logic stb_prev = 0, pulse_prev = 0;
  logic [7:0] mem [256];
  typedef struct packed {logic port; logic err; logic [7:0] dat;} exp_t;
  exp_t sb[$];

  keyvalue_arbiter #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .A_STB_i(A_STB_i), .A_WE_i(A_WE_i), .A_ADR_i(A_ADR_i), .A_DAT_i(A_DAT_i),
    .A_DAT_o(A_DAT_o), .A_ACK_o(A_ACK_o), .A_ERR_o(A_ERR_o),
    .B_STB_i(B_STB_i), .B_WE_i(B_WE_i), .B_ADR_i(B_ADR_i), .B_DAT_i(B_DAT_i),
    .B_DAT_o(B_DAT_o), .B_ACK_o(B_ACK_o), .B_ERR_o(B_ERR_o),
    .M_STB_o(M_STB_o), .M_WE_o(M_WE_o), .M_ADR_o(M_ADR_o), .M_DAT_o(M_DAT_o),
    .M_DAT_i(M_DAT_i), .M_ACK_i(M_ACK_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Store model: ACKs in the ack_lat-th strobe cycle (0 = never).
  always @(negedge sys_clk) begin
    M_ACK_i = 1'b0;
    if (M_STB_o) begin
      if (!stb_prev) stb_len = 0;
      stb_len++;
      if (stb_len == ack_lat) begin
        M_ACK_i = 1'b1;
        M_DAT_i = mem[M_ADR_o];
        if (M_WE_o) mem[M_ADR_o] = M_DAT_o;
      end
    end
    stb_prev = M_STB_o;
  end

  always @(negedge sys_clk) begin
    logic pa, pb;
    exp_t e;
    pa = A_ACK_o | A_ERR_o;
    pb = B_ACK_o | B_ERR_o;
    if (sys_rst_n && (pa || pb)) begin
      chk("pulse_width", {31'd0, pulse_prev}, 32'd0);
      if (sb.size() == 0) chk("unexpected_pulse", {30'd0, pa, pb}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_port", {30'd0, pa, pb}, e.port ? 32'd1 : 32'd2);
        chk("sb_kind", e.port ? {30'd0, B_ACK_o, B_ERR_o} : {30'd0, A_ACK_o, A_ERR_o}, e.err ? 32'd1 : 32'd2);
        chk("sb_dat", {24'd0, e.port ? B_DAT_o : A_DAT_o}, {24'd0, e.dat});
      end
    end
    pulse_prev = sys_rst_n & (pa | pb);
  end

  task automatic do_req(input logic port, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                        input int lat, input logic exp_err, input logic [7:0] exp_dat, input int exp_lat);
    int n;
    logic seen, done;
    sb.push_back('{port, exp_err, exp_dat});
    ack_lat = lat;
    @(negedge sys_clk);
    if (port) begin B_STB_i = 1; B_WE_i = we; B_ADR_i = adr; B_DAT_i = dat; end
    else begin A_STB_i = 1; A_WE_i = we; A_ADR_i = adr; A_DAT_i = dat; end
    n = 0; seen = 0; done = 0;
    while (!done && n < 100) begin
      @(negedge sys_clk);
      n++;
      if (M_STB_o && !seen) begin
        seen = 1;
        chk("m_fields", {grant_o, M_WE_o, M_ADR_o, we ? M_DAT_o : 8'd0},
            {port ? 2'b10 : 2'b01, we, adr, we ? dat : 8'd0});
      end
      done = port ? (B_ACK_o | B_ERR_o) : (A_ACK_o | A_ERR_o);
    end
    if (!done) chk("req_timeout", 32'd0, 32'd1);
    if (exp_lat > 0) chk("req_latency", n, exp_lat);
    if (port) B_STB_i = 0; else A_STB_i = 0;
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst_n = 0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h34] = 8'hC3;
    #3;
    chk("reset_outputs", {A_DAT_o, B_DAT_o, A_ACK_o, A_ERR_o, B_ACK_o, B_ERR_o, M_STB_o, M_WE_o, busy_o, grant_o},
        32'd0);
    chk("reset_m_bus", {M_ADR_o, M_DAT_o, err_cnt_o}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1;
    @(negedge sys_clk);
    chk("idle_after_reset", {29'd0, busy_o, grant_o}, 32'd0);

    do_req(0, 1, 8'h12, 8'h5A, 1, 0, 8'h00, 2);
    do_req(0, 0, 8'h12, 8'h00, 1, 0, 8'h5A, 2);
    chk("b_untouched", {B_DAT_o, B_ACK_o, B_ERR_o}, 32'd0);

    apply_reset();
    ack_lat = 1;
    A_WE_i = 0; A_ADR_i = 8'h12; B_WE_i = 0; B_ADR_i = 8'h34;
    sb.push_back('{1'b0, 1'b0, 8'h5A});
    sb.push_back('{1'b1, 1'b0, 8'hC3});
    sb.push_back('{1'b0, 1'b0, 8'h5A});
    sb.push_back('{1'b1, 1'b0, 8'hC3});
    @(negedge sys_clk);
    A_STB_i = 1; B_STB_i = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      if (i % 3 == 1) chk("grant_seq", {30'd0, grant_o}, (i % 6 == 1) ? 32'd1 : 32'd2);
      if (i == 12) begin
        chk("contention_idle", {31'd0, busy_o}, 32'd0);
        A_STB_i = 0; B_STB_i = 0;
      end
    end

    do_req(1, 1, 8'h20, 8'h33, 0, 1, 8'hC3, 16);
    chk("timeout_stb_len", stb_len, 32'd15);
    chk("timeout_err_cnt", {24'd0, err_cnt_o}, 32'd1);
    chk("timeout_no_write", {24'd0, mem[8'h20]}, 32'd0);

    do_req(0, 0, 8'h12, 8'h00, 15, 0, 8'h5A, 16);
    chk("ack_wins_err_cnt", {24'd0, err_cnt_o}, 32'd1);

    ack_lat = 0;
    @(negedge sys_clk);
    A_STB_i = 1; A_WE_i = 0; A_ADR_i = 8'h00;
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 0;
    #1 chk("reset_mid_busy", {28'd0, M_STB_o, busy_o, grant_o}, 32'd0);
    chk("reset_clears_cnt", {24'd0, err_cnt_o}, 32'd0);
    A_STB_i = 0;
    @(negedge sys_clk);
    sys_rst_n = 1;
    repeat (20) @(negedge sys_clk);

    for (int i = 0; i < 260; i++) begin
      do_req(0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0);
      if (i == 253) chk("err_cnt_254", {24'd0, err_cnt_o}, 32'd254);
    end
    chk("err_cnt_saturated", {24'd0, err_cnt_o}, 32'd255);
    repeat (3) @(negedge sys_clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keyvalue_arbiter.md
# keyvalue_arbiter

Two-port arbiter that shares one key-value store instance between the Wishbone-side requester (port A) and the IO-pin requester (port B). It serialises requests with round-robin fairness, drives one registered strobe/address/data transaction at a time into the store, and returns data and ACK to the winning requester. Transactions the store never acknowledges are aborted after a bounded wait and reported as errors. It sits between the wrapper-level request sources and a single `keyvalue` store.

## Interface

Parameters:
- `AW`, 8: key/address width.
- `DW`, 8: data width.
- `TIMEOUT`, 15: cycles `M_STB_o` may stay high without `M_ACK_i` before abort; legal range is ≥1.

Ports:
- `sys_clk` in 1: single clock; all state changes on the rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `A_STB_i` / `B_STB_i` in 1: request strobe; held high until ACK or ERR is seen.
- `A_WE_i` / `B_WE_i` in 1: 1 = write, 0 = read.
- `A_ADR_i` / `B_ADR_i` in AW: key.
- `A_DAT_i` / `B_DAT_i` in DW: write data.
- `A_DAT_o` / `B_DAT_o` out DW: read data, registered.
- `A_ACK_o` / `B_ACK_o` out 1: one-cycle completion pulse.
- `A_ERR_o` / `B_ERR_o` out 1: one-cycle timeout pulse.
- `M_STB_o` out 1: strobe to the store.
- `M_WE_o` out 1: write enable to the store.
- `M_ADR_o` out AW: key to the store.
- `M_DAT_o` out DW: write data to the store.
- `M_DAT_i` in DW: read data from the store.
- `M_ACK_i` in 1: acknowledge from the store.
- `grant_o` out 2: one-hot current owner; bit0 = A, bit1 = B, 00 = none.
- `busy_o` out 1: high when the state is not IDLE.
- `err_cnt_o` out 8: saturating count of timeouts.

## Operation

- **States:** IDLE, BUSY, DONE.
- **IDLE**
  - No strobe active: stay in IDLE.
  - One strobe active: grant that port.
  - Both strobes active: grant the port that was not granted last. `last` resets to B, so A wins the first tie.
  - On a grant, on the same edge:
    - latch the winner's WE/ADR/DAT into `M_WE_o`/`M_ADR_o`/`M_DAT_o`;
    - set `M_STB_o`=1, set `grant_o`, update `last`;
    - clear the timeout counter; go to BUSY.
- **BUSY**
  - `M_STB_o` and the `M_*` fields are held constant.
  - On an edge with `M_ACK_i`=1:
    - `M_STB_o`←0;
    - for a read, the owner's `DAT_o`←`M_DAT_i`; for a write, `DAT_o` is unchanged;
    - owner's `ACK_o`←1; go to DONE.
  - On an edge with `M_ACK_i`=0 and counter == TIMEOUT−1:
    - `M_STB_o`←0; owner's `ERR_o`←1;
    - `err_cnt_o` increments, saturating at 255; go to DONE.
  - Otherwise the counter increments.
  - If ACK and the timeout coincide on the same edge, ACK wins and no error is recorded.
- **DONE**
  - Lasts exactly one cycle.
  - `ACK_o`/`ERR_o` are high during this cycle; both return to 0 on the next edge.
  - `grant_o`←00; go to IDLE.
  - Strobes are ignored in DONE. Requesters drop STB in the DONE cycle, so the same request is not re-sampled.
- The non-owner's `ACK_o`/`ERR_o`/`DAT_o` never change while it is not granted.
- `busy_o` = (state ≠ IDLE).
- The timeout counter width is $clog2(TIMEOUT+1).
- Only one `M_STB_o` transaction is ever outstanding.

## Timing

- **Reset values:** all outputs 0; state IDLE; `last`=B; counter 0.
- **Reset behaviour:** reset acts immediately, including mid-transaction. `M_STB_o` drops without waiting for edge alignment, and no ACK/ERR is produced for the aborted request.
- **Grant latency:** STB high before edge n → `M_STB_o` high after edge n.
- **Minimum round trip:** the store ACKs in the first `M_STB_o` cycle. ACK is sampled at edge n+1, and `ACK_o` is high from n+1 to n+2.
  - Earliest next grant is edge n+3, so back-to-back throughput is 1 transaction per 3 cycles.
- **Timeout:** `M_STB_o` is high for exactly TIMEOUT cycles. `ERR_o` is high in the cycle immediately after.
- **`M_ACK_i` outside BUSY:** ignored.

## Test plan

1. **Reset:** assert `sys_rst_n`=0 → all outputs 0. After release, IDLE with `busy_o`=0.
2. **A write then A read:**
   - A writes key 0x12 data 0x5A; store ACKs on its first `M_STB_o` cycle → `A_ACK_o` pulses once, 2 cycles after STB is sampled.
   - A then reads key 0x12; store returns 0x5A → `A_DAT_o`=0x5A.
   - `B_*` outputs stay 0 throughout.
3. **Contention:** A and B both hold STB continuously, with the store ACKing immediately → grants alternate A, B, A, B, and each transaction takes 3 cycles.
4. **Timeout:** TIMEOUT=15, store never ACKs a B request → `M_STB_o` high for 15 cycles. Then `B_ERR_o` pulses for 1 cycle, `err_cnt_o`=1, and `B_ACK_o` stays 0.
5. **ACK on the timeout edge:** `M_ACK_i` arrives on the 15th `M_STB_o` cycle → ACK pulse only, no ERR, `err_cnt_o` unchanged.
6. **Reset mid-BUSY and saturation:**
   - Pull `sys_rst_n` low on cycle 3 of BUSY → `M_STB_o`=0 at once, with no ACK/ERR afterward.
   - Force 260 timeouts → `err_cnt_o`=255.
